mem_access_ctrl: RTL

Sequencer between the MEM stage of the 64-bit core and the single-port data memory bus. It accepts one load or store per request handshake and generates the byte-lane write mask and lane-shifted write data for each bus beat. It splits any access that crosses an 8-byte boundary into two aligned beats, then merges and sign- or zero-extends load data. It holds the pipeline through `req_ready` until the access completes.

---
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a single-port 64-bit data bus.
// It splits accesses that cross a doubleword into two aligned beats and merges/extends load data.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_width,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wmask,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned LANES  = 8;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t              state;
  logic                lat_we;
  logic [2:0]          lat_width;
  logic [2:0]          lat_off;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   lo_rdata;

  logic [3:0]          lat_size;
  logic                lat_split;
  logic [2*LANES-1:0]  lat_mask2;
  logic [2*DATA_W-1:0] lat_data2;

  function automatic logic [3:0] width_size(input logic [2:0] w);
    case (w)
      3'b001:         return 4'd8;
      3'b010, 3'b101: return 4'd4;
      3'b011, 3'b110: return 4'd2;
      3'b100, 3'b111: return 4'd1;
      default:        return 4'd0;
    endcase
  endfunction

  // Two-doubleword view of lane enables: low byte is the LO beat, high byte the HI beat.
  function automatic logic [2*LANES-1:0] lane_mask(input logic [3:0] size, input logic [2:0] off);
    logic [2*LANES-1:0] m;
    m = (16'(1) << size) - 16'd1;
    return m << off;
  endfunction

  function automatic logic [2*DATA_W-1:0] lane_data(input logic [DATA_W-1:0] d, input logic [2:0] off);
    return {64'd0, d} << {off, 3'b000};
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] hi,
                                              input logic [2:0] off);
    logic [2*DATA_W-1:0] w;
    w = {hi, lo} >> {off, 3'b000};
    return w[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw, input logic [2:0] w);
    case (w)
      3'b001:  return raw;
      3'b010:  return {{32{raw[31]}}, raw[31:0]};
      3'b101:  return {32'd0, raw[31:0]};
      3'b011:  return {{48{raw[15]}}, raw[15:0]};
      3'b110:  return {48'd0, raw[15:0]};
      3'b100:  return {{56{raw[7]}}, raw[7:0]};
      3'b111:  return {56'd0, raw[7:0]};
      default: return 64'd0;
    endcase
  endfunction

  assign lat_size  = width_size(lat_width);
  assign lat_split = (4'(lat_off) + lat_size) > 4'd8;
  assign lat_mask2 = lane_mask(lat_size, lat_off);
  assign lat_data2 = lane_data(lat_wdata, lat_off);

  // Sequencer; every bus and response output is a register updated on state transitions only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wmask  <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      lat_we     <= 1'b0;
      lat_width  <= '0;
      lat_off    <= '0;
      lat_wdata  <= '0;
      lo_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_width <= req_width;
            lat_off   <= req_addr[2:0];
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            if (req_width == 3'b000) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state     <= LO;
              mem_valid <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[63:3], 3'b000};
              mem_wmask <= 8'(lane_mask(width_size(req_width), req_addr[2:0]));
              mem_wdata <= req_wdata << {req_addr[2:0], 3'b000};
            end
          end
        end
        LO: begin
          if (mem_ready) begin
            lo_rdata <= mem_rdata;
            if (lat_split) begin
              state     <= HI;
              mem_addr  <= mem_addr + 64'd8;
              mem_wmask <= lat_mask2[2*LANES-1:LANES];
              mem_wdata <= lat_data2[2*DATA_W-1:DATA_W];
            end else begin
              state      <= DONE;
              mem_valid  <= 1'b0;
              mem_we     <= 1'b0;
              mem_wmask  <= '0;
              resp_valid <= 1'b1;
              if (!lat_we) resp_rdata <= extend(merge(mem_rdata, 64'd0, lat_off), lat_width);
            end
          end
        end
        HI: begin
          if (mem_ready) begin
            state      <= DONE;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_wmask  <= '0;
            resp_valid <= 1'b1;
            if (!lat_we) resp_rdata <= extend(merge(lo_rdata, mem_rdata, lat_off), lat_width);
          end
        end
        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
